// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_mmio
// Description : Byte-addressable data RAM with a small memory-mapped IO
//               window (switches, LED register, free-running cycle counter).
//               Single-cycle registered load response, byte-lane stores,
//               alignment checking with a misalign pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_mmio #(
  parameter int DEPTH = 4096,
  parameter int SW_W  = 16,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             misalign,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] IO_SW   = 2'b00;
  localparam logic [1:0] IO_LED  = 2'b01;
  localparam logic [1:0] IO_CNT  = 2'b10;

  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [31:0]      cycle_cnt;
  logic             is_io;
  logic [1:0]       io_sel;
  logic [AW-1:0]    word_idx;
  logic             illegal;
  logic [3:0]       be;
  logic [31:0]      st_data;
  logic             ram_we;
  logic             led_we;
  logic [31:0]      ram_word;
  logic [31:0]      rd_word;
  logic [31:0]      shifted;
  logic [31:0]      ld_data;
  logic [LED_W-1:0] led_next;
  logic             unused_addr;

  // Address decode: bit 31 picks IO, RAM index wraps modulo DEPTH.
  assign is_io       = addr[31];
  assign io_sel      = addr[3:2];
  assign word_idx    = addr[AW+1:2];
  assign unused_addr = ^addr[30:AW+2];

  // Size decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    illegal = 1'b0;
    be      = 4'b0000;
    st_data = wdata;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        illegal = addr[0];
        be      = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        illegal = (addr[1:0] != 2'b00);
        be      = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Requests seen during reset must not disturb the (unreset) RAM.
  assign ram_we = req & we & ~illegal & ~is_io & ~rst;
  assign led_we = req & we & ~illegal & is_io & (io_sel == IO_LED);

  // One byte-wide array per lane so each lane maps onto its own RAM column.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Lane write on the store edge; contents are never reset.
      always_ff @(posedge clk) begin
        if (ram_we && be[i]) begin
          lane_mem[word_idx] <= st_data[8*i +: 8];
        end
      end

      assign ram_word[8*i +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Read source select: RAM word or one of the IO registers, zero-extended.
  always_comb begin
    rd_word = '0;
    if (!is_io) begin
      rd_word = ram_word;
    end else begin
      case (io_sel)
        IO_SW:   rd_word[SW_W-1:0]  = sw_sync;
        IO_LED:  rd_word[LED_W-1:0] = led_out;
        IO_CNT:  rd_word            = cycle_cnt;
        default: rd_word            = '0;
      endcase
    end
  end

  // Align the addressed lane(s) to bit 0 and extend sub-word loads.
  always_comb begin
    shifted = rd_word >> {addr[1:0], 3'b000};
    case (size)
      SZ_BYTE: ld_data = uns ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = uns ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Per-bit LED merge so unselected lanes keep their value.
  generate
    for (genvar i = 0; i < LED_W; i++) begin : g_led_bit
      assign led_next[i] = be[i/8] ? st_data[i] : led_out[i];
    end
  endgenerate

  // LED register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
    end else if (led_we) begin
      led_out <= led_next;
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // Response register: load data or an error response, one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      if (req && illegal) begin
        rdata    <= '0;
        rvalid   <= 1'b1;
        misalign <= 1'b1;
      end else if (req && !we) begin
        rdata    <= ld_data;
        rvalid   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_mmio
// Description : Self-checking bench for data_mem_mmio with a response
//               scoreboard and a small RAM reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_mmio;

  localparam int SW_W  = 16;
  localparam int LED_W = 16;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             req    = 1'b0;
  logic             we     = 1'b0;
  logic             uns    = 1'b0;
  logic [1:0]       size   = 2'b00;
  logic [31:0]      addr   = '0;
  logic [31:0]      wdata  = '0;
  logic [SW_W-1:0]  sw_in  = '0;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             misalign;
  logic [LED_W-1:0] led_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hold_exp = '0;
  logic [31:0] tb_cnt;
  logic [31:0] model [8];

  always #5 clk = ~clk;

  data_mem_mmio #(
    .DEPTH (4096),
    .SW_W  (SW_W),
    .LED_W (LED_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .uns      (uns),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .misalign (misalign),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  // Reference count of non-reset edges: the value a counter read samples.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 32'd1;
  end

  // Response monitor: pop the scoreboard on rvalid, check holds otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      hold_exp = '0;
    end else if (rvalid) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", {31'b0, rvalid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check(e.tag, rdata, e.data);
        check({e.tag, "_mis"}, {31'b0, misalign}, {31'b0, e.mis});
        hold_exp = e.data;
      end
    end else begin
      check("rdata_hold", rdata, hold_exp);
      check("misalign_idle", {31'b0, misalign}, 32'h0);
    end
  end

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz,
                                      input logic u, input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (sz)
      2'd0:    return u ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    return u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0:    r[8*off +: 8]  = d[7:0];
      2'd1:    r[8*off +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, sz, 1'b0, a, d);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] expv);
    sb.push_back('{tag, expv, 1'b0});
    drive(1'b0, sz, u, a, 32'h0);
  endtask

  task automatic bad(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
    sb.push_back('{tag, 32'h0, 1'b1});
    drive(w, sz, 1'b0, a, 32'hFFFF_FFFF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          idx;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        u;
    logic [31:0] d;
    logic [31:0] a;

    #1 rst = 1'b1;
    #2;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Store then immediate load of the same word.
    store(2'd2, 32'h10, 32'h8899AABB);
    load("ld_w10", 2'd2, 1'b0, 32'h10, 32'h8899AABB);

    // Byte store and sub-word loads with both extensions.
    store(2'd0, 32'h11, 32'hF0);
    load("ld_sb11", 2'd0, 1'b0, 32'h11, 32'hFFFFFFF0);
    load("ld_ub11", 2'd0, 1'b1, 32'h11, 32'h000000F0);
    load("ld_w10b", 2'd2, 1'b0, 32'h10, 32'h8899F0BB);
    load("ld_sh12", 2'd1, 1'b0, 32'h12, 32'hFFFF8899);
    load("ld_uh12", 2'd1, 1'b1, 32'h12, 32'h00008899);

    // Illegal accesses: error response, store suppressed.
    store(2'd2, 32'h20, 32'h11223344);
    bad("ld_h13", 1'b0, 2'd1, 32'h13);
    bad("st_w22", 1'b1, 2'd2, 32'h22);
    bad("ld_sz3", 1'b0, 2'd3, 32'h20);
    load("ld_w20", 2'd2, 1'b0, 32'h20, 32'h11223344);

    // Switches through the synchronizer.
    sw_in = 16'h5A5A;
    idle(3);
    load("ld_sw", 2'd2, 1'b0, 32'h80000000, 32'h00005A5A);

    // LED register with lane-preserving byte store.
    store(2'd2, 32'h80000004, 32'h1234);
    check("led_w", {16'h0, led_out}, 32'h1234);
    store(2'd0, 32'h80000005, 32'hFF);
    check("led_b", {16'h0, led_out}, 32'hFF34);

    // Stores to read-only / reserved offsets are ignored silently.
    store(2'd2, 32'h80000000, 32'h0);
    store(2'd2, 32'h8000000C, 32'h77);
    store(2'd2, 32'h80000008, 32'h55);
    load("ld_led", 2'd2, 1'b0, 32'h80000004, 32'h0000FF34);
    load("ld_led_ub", 2'd0, 1'b1, 32'h80000005, 32'h000000FF);
    load("ld_led_sb", 2'd0, 1'b0, 32'h80000005, 32'hFFFFFFFF);
    load("ld_sw2", 2'd2, 1'b0, 32'h80000000, 32'h00005A5A);
    load("ld_rsv", 2'd2, 1'b0, 32'h8000000C, 32'h0);

    // Counter reads, back to back.
    load("ld_cnt", 2'd2, 1'b0, 32'h80000008, tb_cnt);
    load("ld_cnt2", 2'd2, 1'b0, 32'h80000008, tb_cnt);

    // Index wraps modulo DEPTH.
    store(2'd2, 32'h4000, 32'hCAFEF00D);
    load("ld_wrap", 2'd2, 1'b0, 32'h0, 32'hCAFEF00D);

    // Randomized mixed stores/loads against a reference model.
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      store(2'd2, 32'h200 + 32'(4 * i), model[i]);
    end
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 7);
      sz  = 2'($urandom_range(0, 2));
      u   = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (sz == 2'd0)      off = 2'($urandom_range(0, 3));
      else if (sz == 2'd1) off = {1'($urandom_range(0, 1)), 1'b0};
      else                 off = 2'd0;
      a = 32'h200 + 32'(4 * idx) + {30'h0, off};
      if ($urandom_range(0, 1) == 1) begin
        store(sz, a, d);
        model[idx] = merge(model[idx], d, sz, off);
      end else begin
        load("rand_ld", sz, u, a, ext(model[idx], sz, u, off));
      end
    end

    // Reset in the middle of traffic.
    store(2'd2, 32'h40, 32'h0BADF00D);
    idle(2);
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h80000004;
    #2 rst = 1'b1;
    #1;
    check("midrst_led", {16'h0, led_out}, 32'h0);
    check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
    we = 1'b1; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    rst = 1'b0;
    load("cnt_after_rst", 2'd2, 1'b0, 32'h80000008, 32'h0);
    load("ld_40", 2'd2, 1'b0, 32'h40, 32'h0BADF00D);
    load("led_after_rst", 2'd2, 1'b0, 32'h80000004, 32'h0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    idle(1);
    check("sb_drain", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit data words; it is a power of 2, >= 16.
REQ-002 The block SHALL have parameter SW_W, default 16, meaning switch input width (1..32).
REQ-003 The block SHALL have parameter LED_W, default 16, meaning LED output width (1..32).
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req, input, 1 bit: access request; it is sampled every clk edge and has no backpressure.
REQ-007 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load; valid with req.
REQ-008 The block SHALL have port size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 The block SHALL have port uns, input, 1 bit: 1 = zero-extend a sub-word load, 0 = sign-extend it.
REQ-010 The block SHALL have port addr, input, 32 bits: byte address.
REQ-011 The block SHALL have port wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 The block SHALL have port rdata, output, 32 bits: load result, registered.
REQ-013 The block SHALL have port rvalid, output, 1 bit: one-cycle pulse marking the response to a load or an illegal access.
REQ-014 The block SHALL have port misalign, output, 1 bit: one-cycle pulse marking an illegal access.
REQ-015 The block SHALL have port sw_in, input, SW_W bits: asynchronous switch levels.
REQ-016 The block SHALL have port led_out, output, LED_W bits: LED register.

Function
REQ-017 The block SHALL decode the region as: addr[31]=0 selects RAM at word index addr[log2(DEPTH)+1:2], with upper bits ignored so the index wraps modulo DEPTH; addr[31]=1 selects IO by addr[3:2].
REQ-018 The block SHALL map IO offsets as: 0 switches (read-only, zero-extended to 32 bits); 1 LED register (read/write, zero-extended); 2 cycle counter (read-only); 3 reserved (reads 0).
REQ-019 Stores to read-only or reserved IO offsets SHALL be ignored without a fault.
REQ-020 Byte stores SHALL write byte lane addr[1:0]; half stores SHALL write lanes {addr[1],0} and {addr[1],1}; word stores SHALL write all four lanes; unselected lanes SHALL be preserved, in both RAM and the LED register.
REQ-021 A store SHALL take effect at the clk edge on which req=1 and we=1 are sampled, and SHALL produce no rvalid pulse.
REQ-022 A load sampled at edge N SHALL return rdata and rvalid=1 after edge N+1 (latency 1); rvalid SHALL be 0 on every other cycle.
REQ-023 rdata SHALL hold its last value when rvalid=0.
REQ-024 Load data SHALL be the addressed lane(s) shifted to bit 0, then extended according to uns; word loads SHALL ignore uns.
REQ-025 A load issued the cycle after a store to the same word SHALL return the post-store data.
REQ-026 An access is illegal when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
REQ-027 For an illegal access: any store SHALL be suppressed; after the next edge misalign=1, rvalid=1 and rdata=0, for both loads and stores.
REQ-028 sw_in SHALL pass through a 2-flop synchronizer, and a switch read SHALL return the synchronized value.
REQ-029 The cycle counter SHALL be 32-bit, increment every cycle, and wrap from 0xFFFFFFFF to 0.
REQ-030 A counter read SHALL return the counter value at the sampling edge.
REQ-031 Back-to-back requests SHALL be accepted every cycle with one response per load, in order.

Reset
REQ-032 When rst=1, the block SHALL set rdata=0, rvalid=0, misalign=0, led_out=0, counter=0 and both synchronizer stages=0, immediately and without waiting for clk.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 A request sampled while rst=1 SHALL be discarded, SHALL write nothing, and SHALL produce no rvalid after deassertion.
REQ-035 The counter SHALL read 0 at the first edge after rst deasserts.

Verification
REQ-036 Store word 0x8899AABB to 0x10, then load word from 0x10 on the next cycle -> rdata=0x8899AABB with rvalid one cycle later.
REQ-037 Store byte 0xF0 to 0x11, then load signed byte 0x11 -> 0xFFFFFFF0, load unsigned byte -> 0x000000F0, load word 0x10 -> 0x8899F0BB.
REQ-038 Load half from 0x13 -> misalign=1, rvalid=1, rdata=0; store word to 0x22 -> misalign pulse and RAM word 0x20 unchanged.
REQ-039 sw_in=0x5A5A, wait 3 cycles, load 0x80000000 -> 0x00005A5A; store word 0x1234 to 0x80000004 -> led_out=0x1234; store byte 0xFF to 0x80000005 -> led_out=0xFF34.
REQ-040 With DEPTH=4096, store to 0x4000, then load 0x0 -> same data (wrap).
REQ-041 Assert rst mid-stream during a load request -> rvalid stays 0, led_out=0 at once, and a counter read issued at the first edge after release returns 0.
